// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_stage
//  Purpose  : Pipeline stage-4 memory-access controller. Passes ALU results
//             straight through, and for loads/stores runs one request over a
//             req/ack data-memory port. The upstream pipeline is held via
//             `stall` until the access completes or times out. Byte/half/word
//             lane steering and load sign/zero extension are handled here.
//  Ports    : clk, rst_n (async, active-low)
//             valid_in, mem_read_in, mem_write_in, size_in, sign_ext_in,
//             addr_in, wdata_in, regfile_w_en_in, regfile_req_w_in : EX result
//             mem_req, mem_we, mem_addr, mem_be, mem_wdata          : request
//             mem_ack, mem_rdata                                    : response
//             data, regfile_w_en, regfile_req_w, r_datamem          : writeback
//             stall, misalign_err, bus_err                          : control
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [1:0]  size_in,
    input  logic        sign_ext_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic        regfile_w_en_in,
    input  logic [4:0]  regfile_req_w_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] data,
    output logic        regfile_w_en,
    output logic [4:0]  regfile_req_w,
    output logic        r_datamem,
    output logic        stall,
    output logic        misalign_err,
    output logic        bus_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [31:0]       mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic [31:0]       rdata_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    // Lane/size/extension of the access in flight, captured at issue so the
    // response is decoded against the request that was actually sent.
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              sext_q;

    logic              mem_op_d;
    logic              aligned_d;
    logic [3:0]        be_d;
    logic [31:0]       wdata_d;
    logic [7:0]        lane_b_d;
    logic [15:0]       lane_h_d;
    logic [31:0]       load_d;

    assign mem_op_d = valid_in & (mem_read_in | mem_write_in);

    // Alignment check, byte enables and store-data replication for the new op
    always_comb begin
        aligned_d = 1'b1;
        be_d      = 4'b1111;
        wdata_d   = wdata_in;
        case (size_in)
            2'b00: begin
                aligned_d = 1'b1;
                be_d      = 4'b0001 << addr_in[1:0];
                wdata_d   = {4{wdata_in[7:0]}};
            end
            2'b01: begin
                aligned_d = ~addr_in[0];
                be_d      = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_d   = {2{wdata_in[15:0]}};
            end
            default: begin
                aligned_d = (addr_in[1:0] == 2'b00);
                be_d      = 4'b1111;
                wdata_d   = wdata_in;
            end
        endcase
    end

    // Load lane selection and extension from the returned word
    always_comb begin
        lane_b_d = mem_rdata[{off_q, 3'b000} +: 8];
        lane_h_d = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            2'b00:   load_d = {{24{sext_q & lane_b_d[7]}}, lane_b_d};
            2'b01:   load_d = {{16{sext_q & lane_h_d[15]}}, lane_h_d};
            default: load_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_be_q    <= 4'd0;
            mem_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            off_q       <= 2'd0;
            size_q      <= 2'd0;
            sext_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_op_d && aligned_d) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= mem_write_in;
                        mem_addr_q  <= {addr_in[31:2], 2'b00};
                        mem_be_q    <= be_d;
                        mem_wdata_q <= wdata_d;
                        off_q       <= addr_in[1:0];
                        size_q      <= size_in;
                        sext_q      <= sign_ext_in;
                        cnt_q       <= '0;
                        err_q       <= 1'b0;
                        state_q     <= BUSY;
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still wins over timeout
                    if (mem_ack) begin
                        rdata_q   <= load_d;
                        mem_req_q <= 1'b0;
                        state_q   <= DONE;
                    end else if (cnt_q == CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        err_q     <= 1'b1;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    // Upstream advances at the end of DONE; never reissue here
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_we        = mem_we_q;
    assign mem_addr      = mem_addr_q;
    assign mem_be        = mem_be_q;
    assign mem_wdata     = mem_wdata_q;
    assign regfile_req_w = regfile_req_w_in;

    always_comb begin
        data         = addr_in;
        regfile_w_en = 1'b0;
        r_datamem    = 1'b0;
        stall        = 1'b0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op_d) begin
                    if (aligned_d) begin
                        stall = 1'b1;
                    end else begin
                        misalign_err = 1'b1;
                    end
                end else begin
                    regfile_w_en = valid_in & regfile_w_en_in;
                end
            end
            BUSY: begin
                stall = 1'b1;
            end
            DONE: begin
                data         = mem_read_in ? rdata_q : addr_in;
                regfile_w_en = mem_read_in & regfile_w_en_in & ~err_q;
                r_datamem    = mem_read_in;
                bus_err      = err_q;
            end
            default: begin
                data = addr_in;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_stage
//  Purpose  : Scoreboard bench for mem_access_stage. Directed operations push
//             expected writeback and memory-request records into queues; a
//             monitor pops and compares them when the DUT retires an
//             instruction or raises a new memory request.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in, mem_read_in, mem_write_in, sign_ext_in;
    logic [1:0]  size_in;
    logic [31:0] addr_in, wdata_in;
    logic        regfile_w_en_in;
    logic [4:0]  regfile_req_w_in;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] data;
    logic        regfile_w_en, r_datamem, stall, misalign_err, bus_err;
    logic [4:0]  regfile_req_w;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic        wen;
        logic [4:0]  rd;
        logic        rdm;
        logic        berr;
        logic        merr;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } rq_t;

    wb_t wb_q[$];
    rq_t rq_q[$];

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_in         (valid_in),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .size_in          (size_in),
        .sign_ext_in      (sign_ext_in),
        .addr_in          (addr_in),
        .wdata_in         (wdata_in),
        .regfile_w_en_in  (regfile_w_en_in),
        .regfile_req_w_in (regfile_req_w_in),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_be           (mem_be),
        .mem_wdata        (mem_wdata),
        .mem_ack          (mem_ack),
        .mem_rdata        (mem_rdata),
        .data             (data),
        .regfile_w_en     (regfile_w_en),
        .regfile_req_w    (regfile_req_w),
        .r_datamem        (r_datamem),
        .stall            (stall),
        .misalign_err     (misalign_err),
        .bus_err          (bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic push_wb(input logic [31:0] d, input logic cd, input logic wen,
                           input logic [4:0] rd, input logic rdm, input logic berr,
                           input logic merr);
        wb_t e;
        e.data = d; e.chk_data = cd; e.wen = wen; e.rd = rd;
        e.rdm = rdm; e.berr = berr; e.merr = merr;
        wb_q.push_back(e);
    endtask

    task automatic push_rq(input logic [31:0] a, input logic we, input logic [3:0] be,
                           input logic [31:0] wd);
        rq_t r;
        r.addr = a; r.we = we; r.be = be; r.wdata = wd;
        rq_q.push_back(r);
    endtask

    // Monitor: compares on retirement and on every fresh memory request
    initial begin
        logic req_prev;
        wb_t  e;
        rq_t  r;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && valid_in && !stall) begin
                if (wb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL wb_unexpected actual=retire addr=%h expected=none", addr_in);
                end else begin
                    e = wb_q.pop_front();
                    if (e.chk_data) chk("wb_data", data, e.data);
                    chk("wb_regfile_w_en", {31'd0, regfile_w_en}, {31'd0, e.wen});
                    chk("wb_regfile_req_w", {27'd0, regfile_req_w}, {27'd0, e.rd});
                    chk("wb_r_datamem", {31'd0, r_datamem}, {31'd0, e.rdm});
                    chk("wb_bus_err", {31'd0, bus_err}, {31'd0, e.berr});
                    chk("wb_misalign_err", {31'd0, misalign_err}, {31'd0, e.merr});
                end
            end
            if (mem_req && !req_prev) begin
                if (rq_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rq_unexpected actual=req addr=%h expected=none", mem_addr);
                end else begin
                    r = rq_q.pop_front();
                    chk("rq_addr", mem_addr, r.addr);
                    chk("rq_we", {31'd0, mem_we}, {31'd0, r.we});
                    chk("rq_be", {28'd0, mem_be}, {28'd0, r.be});
                    chk("rq_wdata", mem_wdata, r.wdata);
                end
            end
            req_prev = mem_req;
        end
    end

    // Issue one instruction, act as memory (ack after ack_after request cycles,
    // 0 = never), and check stall/request durations once it retires.
    task automatic run_op(input string name, input logic rd_i, input logic wr_i,
                          input logic [1:0] sz, input logic se,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic wen, input logic [4:0] rd,
                          input int ack_after, input logic [31:0] rdata,
                          input int exp_stalls, input int exp_reqs);
        int  stalls;
        int  reqs;
        bit  retired;
        stalls = 0; reqs = 0; retired = 0;
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = rd_i; mem_write_in = wr_i;
        size_in = sz; sign_ext_in = se; addr_in = addr; wdata_in = wd;
        regfile_w_en_in = wen; regfile_req_w_in = rd;
        mem_ack = 1'b0;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (mem_req) reqs++;
            if (mem_req && ack_after > 0 && reqs == ack_after) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
                mem_ack = 1'b0;
            end
            if (!stall) begin
                retired = 1;
                break;
            end
        end
        mem_ack = 1'b0;
        if (!retired) begin
            checks++; errors++;
            $display("FAIL %s_retire actual=stuck expected=retire", name);
        end else begin
            chk({name, "_stall_cycles"}, stalls, exp_stalls);
            chk({name, "_req_cycles"}, reqs, exp_reqs);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        size_in = 2'b00; sign_ext_in = 1'b0; addr_in = 32'd0; wdata_in = 32'd0;
        regfile_w_en_in = 1'b0; regfile_req_w_in = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        #2 rst_n = 1'b1;

        // ALU pass-through
        push_wb(32'h1234, 1, 1, 5'd5, 0, 0, 0);
        run_op("alu", 0, 0, 2'b10, 0, 32'h1234, 0, 1, 5'd5, 0, 0, 0, 0);
        // ALU with write-enable off
        push_wb(32'hCAFE0000, 1, 0, 5'd9, 0, 0, 0);
        run_op("alu_nowen", 0, 0, 2'b10, 0, 32'hCAFE0000, 0, 0, 5'd9, 0, 0, 0, 0);
        // Signed byte load, lane 3 = 0x80
        push_rq(32'h100, 0, 4'b1000, 32'h0);
        push_wb(32'hFFFFFF80, 1, 1, 5'd7, 1, 0, 0);
        run_op("lb", 1, 0, 2'b00, 1, 32'h103, 0, 1, 5'd7, 1, 32'h80FFFF7F, 2, 1);
        // Half store to upper half
        push_rq(32'h200, 1, 4'b1100, 32'hABCDABCD);
        push_wb(32'h202, 1, 0, 5'd3, 0, 0, 0);
        run_op("sh", 0, 1, 2'b01, 0, 32'h202, 32'h0000ABCD, 1, 5'd3, 2, 0, 3, 2);
        // Misaligned word load
        push_wb(32'h101, 1, 0, 5'd4, 0, 0, 1);
        run_op("lw_mis", 1, 0, 2'b10, 0, 32'h101, 0, 1, 5'd4, 1, 0, 0, 0);
        // Misaligned half load
        push_wb(32'h105, 1, 0, 5'd4, 0, 0, 1);
        run_op("lh_mis", 1, 0, 2'b01, 1, 32'h105, 0, 1, 5'd4, 1, 0, 0, 0);
        // Unsigned half load, upper half
        push_rq(32'h100, 0, 4'b1100, 32'h0);
        push_wb(32'h00008001, 1, 1, 5'd10, 1, 0, 0);
        run_op("lhu", 1, 0, 2'b01, 0, 32'h102, 0, 1, 5'd10, 1, 32'h80011234, 2, 1);
        // Signed half load, lower half
        push_rq(32'h100, 0, 4'b0011, 32'h0);
        push_wb(32'hFFFFF00D, 1, 1, 5'd11, 1, 0, 0);
        run_op("lh", 1, 0, 2'b01, 1, 32'h100, 0, 1, 5'd11, 3, 32'h1234F00D, 4, 3);
        // Unsigned byte load, lane 2
        push_rq(32'h100, 0, 4'b0100, 32'h0);
        push_wb(32'h000000AB, 1, 1, 5'd12, 1, 0, 0);
        run_op("lbu", 1, 0, 2'b00, 0, 32'h102, 0, 1, 5'd12, 1, 32'h00AB0000, 2, 1);
        // Byte store, lane 1
        push_rq(32'h300, 1, 4'b0010, 32'h5A5A5A5A);
        push_wb(32'h301, 1, 0, 5'd0, 0, 0, 0);
        run_op("sb", 0, 1, 2'b00, 0, 32'h301, 32'h1234565A, 0, 5'd0, 1, 0, 2, 1);
        // Word store
        push_rq(32'h500, 1, 4'b1111, 32'hDEADBEEF);
        push_wb(32'h500, 1, 0, 5'd1, 0, 0, 0);
        run_op("sw", 0, 1, 2'b10, 0, 32'h500, 32'hDEADBEEF, 1, 5'd1, 1, 0, 2, 1);
        // Size 11 behaves as word
        push_rq(32'h600, 0, 4'b1111, 32'h0);
        push_wb(32'h11223344, 1, 1, 5'd13, 1, 0, 0);
        run_op("lw_sz3", 1, 0, 2'b11, 1, 32'h600, 0, 1, 5'd13, 1, 32'h11223344, 2, 1);
        // Timeout: no ack, request held TIMEOUT=4 cycles
        push_rq(32'h400, 0, 4'b1111, 32'h0);
        push_wb(32'h0, 0, 0, 5'd14, 1, 1, 0);
        run_op("lw_to", 1, 0, 2'b10, 0, 32'h400, 0, 1, 5'd14, 0, 0, 5, 4);

        // Memory flags without valid_in: no request, no stall; stray ack ignored
        @(posedge clk); #1;
        idle_inputs();
        mem_read_in = 1'b1; size_in = 2'b10; addr_in = 32'h800;
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("novalid_stall", {31'd0, stall}, 32'd0);
            chk("novalid_req", {31'd0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;

        // Reset during BUSY
        push_rq(32'h700, 0, 4'b1111, 32'h0);
        @(posedge clk); #1;
        valid_in = 1'b1; mem_read_in = 1'b1; mem_write_in = 1'b0; size_in = 2'b10;
        sign_ext_in = 1'b0; addr_in = 32'h700; regfile_w_en_in = 1'b1;
        regfile_req_w_in = 5'd15;
        @(negedge clk);
        @(negedge clk);
        chk("busy_req_before_rst", {31'd0, mem_req}, 32'd1);
        #2;
        rst_n = 1'b0;
        valid_in = 1'b0;
        #1;
        chk("rst_busy_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy_stall", {31'd0, stall}, 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle_inputs();

        // Fresh op after reset
        push_rq(32'h300, 0, 4'b1111, 32'h0);
        push_wb(32'hCAFEF00D, 1, 1, 5'd16, 1, 0, 0);
        run_op("lw_post_rst", 1, 0, 2'b10, 0, 32'h300, 0, 1, 5'd16, 2, 32'hCAFEF00D, 3, 2);

        @(posedge clk); #1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("wb_queue_empty", wb_q.size(), 32'd0);
        chk("rq_queue_empty", rq_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
